// File: rtl/alu_iter_if.sv
// Request/response bundle for alu_iter: request handshake with operands and
// op select, response handshake with result and flags.
interface alu_iter_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [3:0]       aluSel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, in1, in2, aluSel, out_ready,
      input  in_ready, out_valid, result, zero, ovf
   );

   modport slave (
      input  in_valid, in1, in2, aluSel, out_ready,
      output in_ready, out_valid, result, zero, ovf
   );
endinterface

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith ops, plus a one-bit-per-cycle
// shift-add multiplier and restoring divider sharing one datapath.
module alu_iter #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_iter_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1011;
   localparam logic [3:0] OP_REMU = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
      return (a_s == b_s) && (r_s != a_s);
   endfunction

   function automatic logic sub_ovf(input logic a_s, input logic b_s, input logic r_s);
      return (a_s != b_s) && (r_s != a_s);
   endfunction

   state_t           r_state;
   logic [SHW:0]     r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_out_valid;

   logic             w_accept;
   logic             w_iter_op;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_dif;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH-1:0] w_rem_dif;
   logic             w_sub_ok;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_fin_res;

   assign bus.in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.ovf       = r_ovf;

   assign w_accept  = bus.in_valid && bus.in_ready;
   assign w_iter_op = (bus.aluSel == OP_MUL) || (bus.aluSel == OP_DIVU) || (bus.aluSel == OP_REMU);
   assign w_shamt   = bus.in2[SHW-1:0];
   assign w_sum     = bus.in1 + bus.in2;
   assign w_dif     = bus.in1 - bus.in2;

   // Single-cycle result and overflow, evaluated on the live request
   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (bus.aluSel)
         OP_AND:  w_res = bus.in1 & bus.in2;
         OP_OR:   w_res = bus.in1 | bus.in2;
         OP_XOR:  w_res = bus.in1 ^ bus.in2;
         OP_ADD: begin
            w_res = w_sum;
            w_ovf = add_ovf(bus.in1[WIDTH-1], bus.in2[WIDTH-1], w_sum[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_dif;
            w_ovf = sub_ovf(bus.in1[WIDTH-1], bus.in2[WIDTH-1], w_dif[WIDTH-1]);
         end
         OP_SLL:  w_res = bus.in1 << w_shamt;
         OP_SRL:  w_res = bus.in1 >> w_shamt;
         OP_SRA:  w_res = $signed(bus.in1) >>> w_shamt;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
         default: w_res = '0;
      endcase
   end

   // Divider remainder is kept in r_acc; the dividend shifts out of r_q as quotient bits shift in
   assign w_rem_sh  = {r_acc, r_q[WIDTH-1]};
   assign w_rem_dif = w_rem_sh[WIDTH-1:0] - r_a;
   assign w_sub_ok  = (w_rem_sh >= {1'b0, r_a});

   // One iteration step of shift-add multiply or restoring divide
   always_comb begin
      w_acc_nxt = r_acc;
      w_q_nxt   = r_q;
      w_a_nxt   = r_a;
      if (r_op == OP_MUL) begin
         w_acc_nxt = r_q[0] ? (r_acc + r_a) : r_acc;
         w_q_nxt   = {1'b0, r_q[WIDTH-1:1]};
         w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
      end else if (w_sub_ok) begin
         w_acc_nxt = w_rem_dif;
         w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
         w_acc_nxt = w_rem_sh[WIDTH-1:0];
         w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
      end
   end

   assign w_fin_res = (r_op == OP_DIVU) ? w_q_nxt : w_acc_nxt;

   // Control FSM with registered result, flags and out_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_op        <= 4'b0000;
         r_a         <= '0;
         r_q         <= '0;
         r_acc       <= '0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept && w_iter_op) begin
                  r_state     <= S_BUSY;
                  r_out_valid <= 1'b0;
                  r_cnt       <= CNT_INIT;
                  r_op        <= bus.aluSel;
                  r_a         <= (bus.aluSel == OP_MUL) ? bus.in1 : bus.in2;
                  r_q         <= (bus.aluSel == OP_MUL) ? bus.in2 : bus.in1;
                  r_acc       <= '0;
               end else if (w_accept) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_res;
                  r_zero      <= (w_res == '0);
                  r_ovf       <= w_ovf;
               end else if ((r_state == S_DONE) && bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end else begin
                  r_state     <= r_state;
               end
            end
            S_BUSY: begin
               r_acc <= w_acc_nxt;
               r_q   <= w_q_nxt;
               r_a   <= w_a_nxt;
               r_cnt <= r_cnt - CNT_LAST;
               if (r_cnt == CNT_LAST) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_fin_res;
                  r_zero      <= (w_fin_res == '0);
                  r_ovf       <= 1'b0;
               end else begin
                  r_state     <= S_BUSY;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter (WIDTH=32): stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_alu_iter;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      string       nm;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        o;
   } vec_t;

   exp_t sb[$];

   vec_t tbl [0:10] = '{
      '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0},
      '{4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0},
      '{4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0},
      '{4'b0100, 32'h00000001, 32'h00000023, 32'h00000008, 1'b0},
      '{4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0},
      '{4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0},
      '{4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0},
      '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
      '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
      '{4'b1101, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0},
      '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}
   };

   alu_iter_if #(.WIDTH(32)) bus ();

   alu_iter #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Drive a request from a negedge, wait for acceptance, record the expectation
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo, input string nm);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.aluSel   = op;
      bus.in1      = a;
      bus.in2      = b;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check({nm, "_accept_timeout"}, 64'd0, 64'd1);
      end
      sb.push_back('{res: er, ovf: eo, nm: nm});
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in1      = 32'hDEADBEEF;
      bus.in2      = 32'h0BADF00D;
      bus.aluSel   = 4'b0010;
   endtask

   // Called right after issue() of an iterative op; measures accept-to-valid latency
   task automatic wait_done(input string nm);
      int lat;
      logic bad;
      lat = 1;
      bad = 1'b0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, 64'(lat), 64'd33);
      check({nm, "_busy_ready"}, {63'd0, bad}, 64'd0);
   endtask

   // Monitor: every output transfer must match the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check({e.nm, "_result"}, {32'd0, bus.result}, {32'd0, e.res});
               check({e.nm, "_zero"}, {63'd0, bus.zero}, {63'd0, (e.res == 32'd0)});
               check({e.nm, "_ovf"}, {63'd0, bus.ovf}, {63'd0, e.ovf});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in1       = 32'd0;
      bus.in2       = 32'd0;
      bus.aluSel    = 4'b0000;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_result", {32'd0, bus.result}, 64'd0);
      check("rst_zero", {63'd0, bus.zero}, 64'd0);
      check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Signed-overflow add, accepted on the first edge after reset
      issue(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, "add_ovf");
      @(negedge clk);
      check("add_valid_one_cycle", {63'd0, bus.out_valid}, 64'd0);

      // Back-to-back sub then sra, one result per cycle
      issue(4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, "sub_zero");
      check("b2b_ready_1", {63'd0, bus.in_ready}, 64'd1);
      issue(4'b0111, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, "sra");
      check("b2b_ready_2", {63'd0, bus.in_ready}, 64'd1);

      for (int i = 0; i <= 10; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].o, $sformatf("vec%0d", i));
      end
      @(negedge clk);

      issue(4'b1010, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, "mul");
      wait_done("mul");
      issue(4'b1010, 32'd6, 32'd7, 32'd42, 1'b0, "mul_small");
      wait_done("mul_small");
      issue(4'b1011, 32'd100, 32'd7, 32'd14, 1'b0, "divu");
      wait_done("divu");
      issue(4'b1100, 32'd100, 32'd7, 32'd2, 1'b0, "remu");
      wait_done("remu");
      issue(4'b1011, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, "divu_by0");
      wait_done("divu_by0");
      issue(4'b1100, 32'd9, 32'd0, 32'd9, 1'b0, "remu_by0");
      wait_done("remu_by0");
      @(negedge clk);

      // Back-pressure: outputs must hold while out_ready is low
      bus.out_ready = 1'b0;
      issue(4'b1000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, "slt_hold");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold_valid_%0d", i), {63'd0, bus.out_valid}, 64'd1);
         check($sformatf("hold_result_%0d", i), {32'd0, bus.result}, 64'd1);
         check($sformatf("hold_ready_%0d", i), {63'd0, bus.in_ready}, 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset in the middle of a divide aborts it without an output pulse
      issue(4'b1011, 32'd1000, 32'd3, 32'd333, 1'b0, "divu_abort");
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("abort_result", {32'd0, bus.result}, 64'd0);
      void'(sb.pop_back());
      repeat (2) @(negedge clk);
      check("abort_hold_valid", {63'd0, bus.out_valid}, 64'd0);
      rst_n = 1'b1;
      check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
      issue(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, "add_after_rst");

      repeat (40) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
